mpeg2_frame_sched: RTL and testbench
====================================

# mpeg2_frame_sched

Ping-pong frame-buffer scheduler between the host register bus and the MPEG2 encoder core. The host fills two frame buffers alternately and commits each; this block tracks buffer ownership, starts the core on each committed buffer in order, and counts completed frames. It enforces a watchdog timeout per frame and raises an interrupt. It presents the same 8-bit-address, 32-bit-data register port as the other MPEG2 peripherals.

## Interface
- `TIMEOUT`, default 32'd1000000: reset value of the watchdog register, in clock cycles; 0 disables.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `addr` in 8: register address.
- `rd_en` in 1: read strobe.
- `wr_en` in 1: write strobe.
- `dataIn` in 32: write data.
- `dataOut` out 32: read data; combinational; 0 when `rd_en`=0 or unmapped address.
- `enc_start` out 1: one-cycle start pulse to the core.
- `enc_buf_sel` out 1: buffer index the core must use; valid while `enc_start` is high and throughout RUN.
- `enc_abort` out 1: one-cycle pulse on watchdog expiry.
- `enc_done` in 1: one-cycle pulse from the core on frame completion.
- `irq` out 1: `irq_pend & irq_en`.

## Operation
- Buffer states: B0 and B1 are each EMPTY, FULL or BUSY.
- Pointers: `hbuf` is the next buffer the host fills; `ebuf` is the next buffer the core consumes.
- Register 0x00 write: bit0 commit (pulse), bit1 enable (level, stored), bit2 irq_en (level, stored), bit3 clear_err (pulse).
- Register 0x00 read: bit0 ready (B[hbuf]==EMPTY), bit1 B0!=EMPTY, bit2 B1!=EMPTY, bit3 enable, bit4 irq_en, bit5 overflow, bit6 timeout, bit7 irq_pend, bits11:8 FSM state, bit12 hbuf, bit13 ebuf. All other bits 0.
- Register 0x01: frame counter, 32-bit, wraps. Read returns the count; any write clears it to 0.
- Register 0x02: watchdog cycles, read/write, full 32 bits.
- Commit:
  - If B[hbuf]==EMPTY, B[hbuf] becomes FULL and hbuf toggles.
  - Otherwise, sticky overflow is set and there is no other change.
- clear_err clears overflow, timeout and irq_pend. It also moves the FSM from ERR to IDLE.
- FSM state codes: IDLE=0, START=1, RUN=2, ERR=3.
  - IDLE: if enable=1 and B[ebuf]==FULL, go to START.
  - START: assert `enc_start` for 1 cycle, set B[ebuf] to BUSY, clear the watchdog counter, go to RUN.
  - RUN, on `enc_done`:
    - B[ebuf] becomes EMPTY, ebuf toggles, and the frame counter increments.
    - If irq_en=1, irq_pend is set.
    - Go to IDLE.
  - RUN, watchdog expiry (watchdog≠0, counter reaches watchdog−1 with no `enc_done`):
    - Pulse `enc_abort`.
    - B[ebuf] becomes EMPTY and ebuf toggles (frame dropped).
    - Set timeout; set irq_pend if irq_en=1.
    - Go to ERR.
  - ERR: no starts; leaves only on clear_err.
- `enc_done` in IDLE, START or ERR is ignored.
- Clearing enable during RUN does not abort: the current frame completes and no new START occurs.

## Timing
- Reset value is 0 for every output and register except watchdog, which resets to `TIMEOUT`.
  - State is IDLE, both buffers EMPTY, hbuf=ebuf=0.
- Register writes take effect at the clock edge where `wr_en`=1.
- A read in the same cycle as a write returns pre-write values.
- Commit to start latency:
  - Commit at edge N gives IDLE→START at N+1 and `enc_start` high during cycle N+1..N+2; RUN begins at N+2.
  - This holds only if the FSM was IDLE with enable=1.
- Back-to-back: `enc_done` at edge M gives IDLE at M+1. If the other buffer is FULL, START follows at M+2, so each frame costs at least 3 cycles.
- Simultaneous events:
  - Commit and `enc_done` in the same cycle: commit is evaluated on pre-edge buffer state, so a BUSY target flags overflow.
  - `enc_done` on the watchdog-expiry cycle: done wins and no timeout is flagged.
  - Frame-counter clear write and increment in the same cycle: clear wins.
  - clear_err and a new irq set in the same cycle: the set wins.
- Reset mid-RUN returns to reset state at the next edge with no `enc_abort` pulse. The core is reset by the same signal.

## Test plan
- Basic frame: reset; write 0x00=0x2 (enable); write 0x00=0x1 (commit) → `enc_start` 1 cycle later with `enc_buf_sel`=0. Drive `enc_done` after 10 cycles → 0x01 reads 1; 0x00 bits1,2 read 0.
- Ping-pong: commit twice, then one more commit before any done → first two commits give no overflow; third sets bit5. Then two `enc_done` → starts alternate `enc_buf_sel`=0,1; count=2; next `enc_start` gap is exactly 3 cycles.
- Watchdog: write 0x02=20; commit with no `enc_done` → `enc_abort` 20 cycles after RUN entry; 0x00 bits11:8=3 and bit6=1. Write 0x00 bit3 → state reads 0; buffer EMPTY.
- Interrupt: irq_en=1, one frame → `irq` rises the cycle after `enc_done`. clear_err drops it. With irq_en=0 → irq stays 0.
- Races: `enc_done` coincident with a commit to the BUSY buffer → overflow set, count increments. `enc_done` on the expiry cycle → no timeout.
- Reset mid-RUN: `reset` during RUN → next cycle all outputs 0, state 0, watchdog reads `TIMEOUT`, counter 0.

Source files
------------

// File: rtl/mpeg2_frame_sched.sv
// Ping-pong frame-buffer scheduler: tracks ownership of two frame buffers between
// host and MPEG2 encoder core, launches the core per committed buffer, and runs a watchdog.
module mpeg2_frame_sched #(
  parameter logic [31:0] TIMEOUT = 32'd1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        enc_start,
  output logic        enc_buf_sel,
  output logic        enc_abort,
  input  logic        enc_done,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [1:0] BUF_EMPTY = 2'd0;
  localparam logic [1:0] BUF_FULL  = 2'd1;
  localparam logic [1:0] BUF_BUSY  = 2'd2;

  state_t      state_reg;
  logic        hbuf_reg;
  logic        ebuf_reg;
  logic        enable_reg;
  logic        irq_en_reg;
  logic        overflow_reg;
  logic        timeout_reg;
  logic        irq_pend_reg;
  logic        enc_start_reg;
  logic        enc_abort_reg;
  logic [31:0] frame_cnt_reg;
  logic [31:0] watchdog_reg;
  logic [31:0] wd_cnt_reg;
  logic [1:0]  buf_state [2];

  logic        ctrl_wr;
  logic        commit_req;
  logic        commit_ok;
  logic        clear_err;
  logic        cnt_clear;
  logic        wd_write;
  logic        start_ev;
  logic        done_ev;
  logic        expire_ev;
  logic        irq_set;
  logic [31:0] status;

  assign ctrl_wr    = wr_en && (addr == 8'h00);
  assign commit_req = ctrl_wr && dataIn[0];
  assign clear_err  = ctrl_wr && dataIn[3];
  assign cnt_clear  = wr_en && (addr == 8'h01);
  assign wd_write   = wr_en && (addr == 8'h02);
  assign commit_ok  = commit_req && (buf_state[hbuf_reg] == BUF_EMPTY);

  assign start_ev  = (state_reg == START);
  assign done_ev   = (state_reg == RUN) && enc_done;
  // >= rather than == so a watchdog shrunk mid-frame still fires instead of waiting for wrap
  assign expire_ev = (state_reg == RUN) && !enc_done && (watchdog_reg != 32'd0) &&
                     (wd_cnt_reg >= watchdog_reg - 32'd1);
  assign irq_set   = irq_en_reg && (done_ev || expire_ev);

  // Host commits only ever touch an EMPTY buffer and the FSM only a non-EMPTY one,
  // so both can update the pair in the same cycle without conflict.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      localparam logic IDX = 1'(gi);
      logic [1:0] st_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          st_reg <= BUF_EMPTY;
        end else if (commit_ok && (hbuf_reg == IDX)) begin
          st_reg <= BUF_FULL;
        end else if (ebuf_reg == IDX) begin
          if (start_ev)
            st_reg <= BUF_BUSY;
          else if (done_ev || expire_ev)
            st_reg <= BUF_EMPTY;
        end
      end

      assign buf_state[gi] = st_reg;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      hbuf_reg      <= 1'b0;
      enable_reg    <= 1'b0;
      irq_en_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
      irq_pend_reg  <= 1'b0;
      frame_cnt_reg <= 32'd0;
      watchdog_reg  <= TIMEOUT;
    end else begin
      if (commit_ok)
        hbuf_reg <= ~hbuf_reg;
      if (ctrl_wr) begin
        enable_reg <= dataIn[1];
        irq_en_reg <= dataIn[2];
      end
      // Clears first so a same-cycle set takes priority
      if (clear_err) begin
        overflow_reg <= 1'b0;
        timeout_reg  <= 1'b0;
        irq_pend_reg <= 1'b0;
      end
      if (commit_req && !commit_ok)
        overflow_reg <= 1'b1;
      if (expire_ev)
        timeout_reg <= 1'b1;
      if (irq_set)
        irq_pend_reg <= 1'b1;
      if (cnt_clear)
        frame_cnt_reg <= 32'd0;
      else if (done_ev)
        frame_cnt_reg <= frame_cnt_reg + 32'd1;
      if (wd_write)
        watchdog_reg <= dataIn;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      ebuf_reg      <= 1'b0;
      wd_cnt_reg    <= 32'd0;
      enc_start_reg <= 1'b0;
      enc_abort_reg <= 1'b0;
    end else begin
      enc_start_reg <= 1'b0;
      enc_abort_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enable_reg && (buf_state[ebuf_reg] == BUF_FULL)) begin
            state_reg     <= START;
            enc_start_reg <= 1'b1;
          end
        end
        START: begin
          state_reg  <= RUN;
          wd_cnt_reg <= 32'd0;
        end
        RUN: begin
          if (done_ev) begin
            state_reg <= IDLE;
            ebuf_reg  <= ~ebuf_reg;
          end else if (expire_ev) begin
            state_reg     <= ERR;
            ebuf_reg      <= ~ebuf_reg;
            enc_abort_reg <= 1'b1;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 32'd1;
          end
        end
        ERR: begin
          if (clear_err)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign status = {18'd0, ebuf_reg, hbuf_reg, 2'd0, state_reg,
                   irq_pend_reg, timeout_reg, overflow_reg, irq_en_reg, enable_reg,
                   buf_state[1] != BUF_EMPTY, buf_state[0] != BUF_EMPTY,
                   buf_state[hbuf_reg] == BUF_EMPTY};

  always_comb begin
    dataOut = 32'd0;
    if (rd_en) begin
      case (addr)
        8'h00:   dataOut = status;
        8'h01:   dataOut = frame_cnt_reg;
        8'h02:   dataOut = watchdog_reg;
        default: dataOut = 32'd0;
      endcase
    end
  end

  assign enc_start   = enc_start_reg;
  assign enc_abort   = enc_abort_reg;
  assign enc_buf_sel = ebuf_reg;
  assign irq         = irq_pend_reg & irq_en_reg;

endmodule

// File: tb/tb_mpeg2_frame_sched.sv
// Bench for mpeg2_frame_sched: random register/done traffic against a cycle-level
// reference model; expected pulses and reads are queued and matched by a monitor.
module tb_mpeg2_frame_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  addr = 8'd0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] dataIn = 32'd0;
  logic        enc_done = 1'b0;
  logic [31:0] dataOut;
  logic        enc_start;
  logic        enc_buf_sel;
  logic        enc_abort;
  logic        irq;

  always #5 clock = ~clock;

  mpeg2_frame_sched dut (
    .clock(clock), .reset(reset), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .dataIn(dataIn), .dataOut(dataOut), .enc_start(enc_start),
    .enc_buf_sel(enc_buf_sel), .enc_abort(enc_abort), .enc_done(enc_done), .irq(irq)
  );

  typedef struct {
    int unsigned cyc;
    logic [31:0] val;
  } exp_t;

  exp_t start_q[$];
  exp_t abort_q[$];
  exp_t read_q[$];

  int vectors = 0;
  int miscompares = 0;
  int unsigned cyc = 0;

  // Reference model: buffers 0=empty 1=full 2=busy; modes 0=idle 1=start 2=run 3=err
  int m_buf[2];
  int m_mode, m_h, m_e, m_run;
  bit m_en, m_ien, m_ovf, m_to, m_pend;
  int unsigned m_cnt, m_wd;

  function automatic void model_reset();
    m_buf[0] = 0; m_buf[1] = 0;
    m_mode = 0; m_h = 0; m_e = 0; m_run = 0;
    m_en = 0; m_ien = 0; m_ovf = 0; m_to = 0; m_pend = 0;
    m_cnt = 0; m_wd = 32'd1000000;
  endfunction

  function automatic void model_edge();
    bit commit, clr, done_now, exp_now;
    int pre_h;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
    commit = wr_en && addr == 8'h00 && dataIn[0];
    clr    = wr_en && addr == 8'h00 && dataIn[3];
    done_now = 0;
    exp_now  = 0;
    pre_h = m_buf[m_h];
    case (m_mode)
      0: if (m_en && m_buf[m_e] == 1) begin
           m_mode = 1;
           start_q.push_back('{cyc, 32'(m_e)});
         end
      1: begin m_buf[m_e] = 2; m_run = 0; m_mode = 2; end
      2: begin
           m_run++;
           if (enc_done) done_now = 1;
           else if (m_wd != 0 && m_run >= int'(m_wd)) exp_now = 1;
           if (done_now || exp_now) begin
             m_buf[m_e] = 0;
             m_e ^= 1;
             m_mode = done_now ? 0 : 3;
           end
           if (exp_now) abort_q.push_back('{cyc, 32'd1});
         end
      default: if (clr) m_mode = 0;
    endcase
    if (clr) begin m_ovf = 0; m_to = 0; m_pend = 0; end
    if (commit) begin
      if (pre_h == 0) begin m_buf[m_h] = 1; m_h ^= 1; end
      else m_ovf = 1;
    end
    if (exp_now) m_to = 1;
    if ((done_now || exp_now) && m_ien) m_pend = 1;
    if (wr_en && addr == 8'h01) m_cnt = 0;
    else if (done_now) m_cnt++;
    if (wr_en && addr == 8'h02) m_wd = dataIn;
    if (wr_en && addr == 8'h00) begin m_en = dataIn[1]; m_ien = dataIn[2]; end
  endfunction

  function automatic logic [31:0] model_read(logic [7:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      8'h00: begin
        r[0] = (m_buf[m_h] == 0);
        r[1] = (m_buf[0] != 0);
        r[2] = (m_buf[1] != 0);
        r[3] = m_en; r[4] = m_ien; r[5] = m_ovf; r[6] = m_to; r[7] = m_pend;
        r[11:8] = 4'(m_mode);
        r[12] = m_h[0]; r[13] = m_e[0];
      end
      8'h01: r = m_cnt;
      8'h02: r = m_wd;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  always @(posedge clock) model_edge();

  always @(negedge clock) begin
    exp_t e;
    if (enc_start === 1'b1) begin
      vectors++;
      if (start_q.size() == 0) begin
        miscompares++;
        $display("FAIL start_unexpected cyc=%0d got pulse want none", cyc);
      end else begin
        e = start_q.pop_front();
        if (e.cyc != cyc || e.val[0] !== enc_buf_sel) begin
          miscompares++;
          $display("FAIL start cyc=%0d sel=%0b want cyc=%0d sel=%0b", cyc, enc_buf_sel, e.cyc, e.val[0]);
        end else $display("start cyc=%0d sel=%0b", cyc, enc_buf_sel);
      end
    end else if (start_q.size() > 0 && start_q[0].cyc <= cyc) begin
      vectors++; miscompares++;
      e = start_q.pop_front();
      $display("FAIL start_missing cyc=%0d got %b want pulse sel=%0b", cyc, enc_start, e.val[0]);
    end
    if (enc_abort === 1'b1) begin
      vectors++;
      if (abort_q.size() == 0 || abort_q[0].cyc != cyc) begin
        miscompares++;
        $display("FAIL abort_unexpected cyc=%0d got pulse want none", cyc);
      end else begin
        e = abort_q.pop_front();
        $display("abort cyc=%0d", cyc);
      end
    end else if (abort_q.size() > 0 && abort_q[0].cyc <= cyc) begin
      vectors++; miscompares++;
      e = abort_q.pop_front();
      $display("FAIL abort_missing cyc=%0d got %b want pulse", cyc, enc_abort);
    end
    if (rd_en === 1'b1 && read_q.size() > 0) begin
      vectors++;
      e = read_q.pop_front();
      if (dataOut !== e.val) begin
        miscompares++;
        $display("FAIL read a=%02h got %08h want %08h", addr, dataOut, e.val);
      end else $display("read a=%02h data=%08h", addr, dataOut);
    end else if (rd_en !== 1'b1) begin
      vectors++;
      if (dataOut !== 32'd0) begin
        miscompares++;
        $display("FAIL idle_dataout got %08h want 00000000", dataOut);
      end
    end
    vectors++;
    if (irq !== (m_pend && m_ien)) begin
      miscompares++;
      $display("FAIL irq cyc=%0d got %b want %b", cyc, irq, m_pend && m_ien);
    end
    if (m_mode == 1 || m_mode == 2) begin
      vectors++;
      if (enc_buf_sel !== m_e[0]) begin
        miscompares++;
        $display("FAIL buf_sel cyc=%0d got %b want %b", cyc, enc_buf_sel, m_e[0]);
      end
    end
  end

  task automatic drive(bit rd, bit wr, logic [7:0] a, logic [31:0] d, bit done, bit rst);
    @(posedge clock);
    #1;
    reset = rst; rd_en = rd; wr_en = wr; addr = a; dataIn = d; enc_done = done;
    if (rd) read_q.push_back('{cyc, model_read(a)});
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 32'd0, 0, 0);
  endtask

  task automatic wait_mode(int target, int budget);
    int n;
    n = 0;
    while (m_mode != target && n < budget) begin
      drive(0, 0, 8'h00, 32'd0, 0, 0);
      n++;
    end
    if (m_mode != target) begin
      vectors++; miscompares++;
      $display("FAIL wait_mode got %0d want %0d after %0d cycles", m_mode, target, n);
    end
  endtask

  task automatic read_regs();
    drive(1, 0, 8'h00, 32'd0, 0, 0);
    drive(1, 0, 8'h01, 32'd0, 0, 0);
    drive(1, 0, 8'h02, 32'd0, 0, 0);
  endtask

  initial begin
    bit cm, en, ien, clr, dn, rd;
    int r;
    logic [7:0] ra;
    drive(0, 0, 8'h00, 32'd0, 0, 1);
    drive(0, 0, 8'h00, 32'd0, 0, 1);
    read_regs();

    // Basic frame, then counter-clear colliding with done
    drive(0, 1, 8'h00, 32'h2, 0, 0);
    drive(0, 1, 8'h00, 32'h3, 0, 0);
    wait_mode(2, 10);
    idle(9);
    drive(0, 0, 8'h00, 32'd0, 1, 0);
    read_regs();
    drive(0, 1, 8'h00, 32'h3, 0, 0);
    wait_mode(2, 10);
    drive(0, 1, 8'h01, 32'd0, 1, 0);
    read_regs();

    // Ping-pong with overflow and commit racing done on the busy buffer
    drive(0, 1, 8'h00, 32'h7, 0, 0);
    drive(0, 1, 8'h00, 32'h7, 0, 0);
    drive(0, 1, 8'h00, 32'h7, 0, 0);
    wait_mode(2, 10);
    drive(1, 0, 8'h00, 32'd0, 0, 0);
    idle(3);
    drive(0, 1, 8'h00, 32'h7, 1, 0);
    wait_mode(2, 10);
    drive(0, 0, 8'h00, 32'd0, 1, 0);
    read_regs();
    drive(0, 1, 8'h00, 32'hE, 0, 0);
    read_regs();

    // Watchdog: done exactly on the expiry edge, then a real expiry
    drive(0, 1, 8'h02, 32'd5, 0, 0);
    drive(0, 1, 8'h00, 32'h3, 0, 0);
    wait_mode(2, 10);
    idle(3);
    drive(0, 0, 8'h00, 32'd0, 1, 0);
    read_regs();
    drive(0, 1, 8'h02, 32'd20, 0, 0);
    drive(0, 1, 8'h00, 32'h7, 0, 0);
    wait_mode(3, 60);
    read_regs();
    drive(0, 1, 8'h00, 32'hA, 0, 0);
    read_regs();

    // Reset in the middle of a frame
    drive(0, 1, 8'h02, 32'd0, 0, 0);
    drive(0, 1, 8'h00, 32'h3, 0, 0);
    wait_mode(2, 10);
    idle(4);
    drive(0, 0, 8'h00, 32'd0, 0, 1);
    drive(0, 0, 8'h00, 32'd0, 0, 0);
    read_regs();

    for (int i = 0; i < 2500; i++) begin
      r  = int'($urandom_range(0, 99));
      dn = ($urandom_range(0, 11) == 0);
      rd = ($urandom_range(0, 3) == 0);
      if (r < 12) begin
        cm = $urandom_range(0, 1); en = ($urandom_range(0, 9) != 0);
        ien = $urandom_range(0, 1); clr = ($urandom_range(0, 5) == 0);
        drive(rd, 1, 8'h00, {28'd0, clr, ien, en, cm}, dn, 0);
      end else if (r < 15) begin
        drive(rd, 1, 8'h02, ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 40)), dn, 0);
      end else if (r < 17) begin
        drive(rd, 1, 8'h01, $urandom, dn, 0);
      end else if (r < 47) begin
        case ($urandom_range(0, 4))
          0: ra = 8'h00; 1: ra = 8'h01; 2: ra = 8'h02; 3: ra = 8'h03; default: ra = 8'h80;
        endcase
        drive(1, 0, ra, 32'd0, dn, 0);
      end else if (r == 99 && $urandom_range(0, 19) == 0) begin
        drive(0, 0, 8'h00, 32'd0, 0, 1);
      end else begin
        drive(0, 0, 8'h00, 32'd0, dn, 0);
      end
    end
    idle(4);
    read_regs();
    idle(2);

    vectors++;
    if (start_q.size() != 0 || abort_q.size() != 0 || read_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover got start=%0d abort=%0d read=%0d want 0", start_q.size(), abort_q.size(), read_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
